// File: rtl/rle_decoder.sv
// ---------------------------------------------------------------------------
// rle_decoder
//
// Run-length decoder. It reads a compressed frame of (count, symbol) byte
// pairs from a word-addressed single-port memory and expands each pair into
// `count` copies of `symbol`. The expanded bytes are packed little-endian into
// 32-bit words and written back to the same memory starting at out_addr.
// The block also reports how many bytes it decoded.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high
//   start            begin a frame (accepted only in IDLE or DONE)
//   rle_addr         byte address of compressed frame (word aligned)
//   rle_size         compressed length in bytes
//   out_addr         byte address for decoded output (word aligned)
//   out_size         decoded byte count, valid while done=1
//   done             frame finished, held until the next accepted start
//   port_A_clk       memory clock (equal to clk)
//   port_A_addr      memory byte address, low two bits always 0
//   port_A_we        1 = write, 0 = read
//   port_A_data_in   write data towards memory
//   port_A_data_out  read data from memory (registered inside the memory)
// ---------------------------------------------------------------------------
module rle_decoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       out_addr,
    output logic [31:0]       out_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_REQ = 3'd1;
    localparam logic [2:0] S_RD_WAIT= 3'd2;
    localparam logic [2:0] S_PARSE  = 3'd3;
    localparam logic [2:0] S_EXPAND = 3'd4;
    localparam logic [2:0] S_WR     = 3'd5;
    localparam logic [2:0] S_FLUSH  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic        accept;

    // Frame reader registers
    logic [29:0] in_word_addr;
    logic [31:0] bytes_left;
    logic [31:0] in_word;
    logic [1:0]  in_ptr;
    logic        have_count;
    logic [7:0]  count_reg;
    logic [7:0]  cur_byte;

    // Run expander registers
    logic [7:0]  symbol;
    logic [7:0]  run_left;
    logic [31:0] acc;
    logic [1:0]  acc_ptr;
    logic [29:0] wr_word_addr;

    logic [29:0] mem_word_addr;
    logic        unused_bits;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // Decide where to go once a run (or a skipped pair) is finished: flush or
    // finish when the frame is consumed, refetch when the current input word
    // has been fully parsed, otherwise keep parsing the same word.
    function automatic logic [2:0] after_run(input logic [31:0] left,
                                             input logic [1:0]  iptr,
                                             input logic [1:0]  aptr);
        if (left == 32'd0) begin
            after_run = (aptr != 2'd0) ? S_FLUSH : S_DONE;
        end else if (iptr == 2'd0) begin
            after_run = S_RD_REQ;
        end else begin
            after_run = S_PARSE;
        end
    endfunction

    // Select the byte of the input word the parse pointer is on.
    always_comb begin
        cur_byte = in_word[7:0];
        case (in_ptr)
            2'd0:    cur_byte = in_word[7:0];
            2'd1:    cur_byte = in_word[15:8];
            2'd2:    cur_byte = in_word[23:16];
            default: cur_byte = in_word[31:24];
        endcase
    end

    // Next-state logic. A symbol byte whose count is zero is treated exactly
    // like the end of a run, so zero-count pairs cost only their parse cycles.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = (rle_size == 32'd0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ:  state_n = S_RD_WAIT;
            S_RD_WAIT: state_n = S_PARSE;
            S_PARSE: begin
                if (have_count && (count_reg != 8'd0)) begin
                    state_n = S_EXPAND;
                end else begin
                    state_n = after_run(bytes_left - 32'd1, in_ptr + 2'd1, acc_ptr);
                end
            end
            S_EXPAND: begin
                if (acc_ptr == 2'd3) begin
                    state_n = S_WR;
                end else if (run_left == 8'd1) begin
                    state_n = after_run(bytes_left, in_ptr, acc_ptr + 2'd1);
                end else begin
                    state_n = S_EXPAND;
                end
            end
            S_WR: begin
                if (run_left != 8'd0) begin
                    state_n = S_EXPAND;
                end else begin
                    state_n = after_run(bytes_left, in_ptr, 2'd0);
                end
            end
            S_FLUSH:   state_n = S_DONE;
            default:   state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame reader: latches the frame on start, captures input words and
    // walks through their bytes. A count byte is held in count_reg until its
    // symbol arrives, which also covers a pair split across two words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_word_addr <= 30'd0;
            bytes_left   <= 32'd0;
            in_word      <= 32'd0;
            in_ptr       <= 2'd0;
            have_count   <= 1'b0;
            count_reg    <= 8'd0;
        end else if (accept) begin
            in_word_addr <= rle_addr[31:2];
            bytes_left   <= rle_size;
            in_ptr       <= 2'd0;
            have_count   <= 1'b0;
        end else begin
            case (state)
                S_RD_WAIT: begin
                    in_word      <= port_A_data_out;
                    in_word_addr <= in_word_addr + 30'd1;
                end
                S_PARSE: begin
                    bytes_left <= bytes_left - 32'd1;
                    in_ptr     <= in_ptr + 2'd1;
                    if (!have_count) begin
                        count_reg  <= cur_byte;
                        have_count <= 1'b1;
                    end else begin
                        have_count <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Run expander: loads the run on its symbol byte, then places one byte per
    // EXPAND cycle into the accumulator. The accumulator is cleared after every
    // write so a final partial word carries zeros in its unused upper bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            symbol       <= 8'd0;
            run_left     <= 8'd0;
            acc          <= 32'd0;
            acc_ptr      <= 2'd0;
            wr_word_addr <= 30'd0;
            out_size     <= 32'd0;
        end else if (accept) begin
            run_left     <= 8'd0;
            acc          <= 32'd0;
            acc_ptr      <= 2'd0;
            wr_word_addr <= out_addr[31:2];
            out_size     <= 32'd0;
        end else begin
            case (state)
                S_PARSE: begin
                    if (have_count) begin
                        symbol   <= cur_byte;
                        run_left <= count_reg;
                    end
                end
                S_EXPAND: begin
                    acc[{acc_ptr, 3'b000} +: 8] <= symbol;
                    acc_ptr  <= acc_ptr + 2'd1;
                    run_left <= run_left - 8'd1;
                    out_size <= out_size + 32'd1;
                end
                S_WR, S_FLUSH: begin
                    acc          <= 32'd0;
                    acc_ptr      <= 2'd0;
                    wr_word_addr <= wr_word_addr + 30'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // done follows entry into DONE, but stays low on the accepting edge so a
    // restart (including a zero-length one) always shows at least one low cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state_n == S_DONE) && !accept;
        end
    end

    // Memory port decode: reads only in RD_REQ, writes only in WR/FLUSH, and
    // the address and data sit at zero in every other state.
    always_comb begin
        mem_word_addr = 30'd0;
        case (state)
            S_RD_REQ:       mem_word_addr = in_word_addr;
            S_WR, S_FLUSH:  mem_word_addr = wr_word_addr;
            default:        mem_word_addr = 30'd0;
        endcase
    end

    assign port_A_clk     = clk;
    assign port_A_we      = (state == S_WR) || (state == S_FLUSH);
    assign port_A_addr    = {mem_word_addr[ADDR_W-3:0], 2'b00};
    assign port_A_data_in = port_A_we ? acc : 32'd0;

    // Address bits that the word-aligned, ADDR_W-wide port never carries.
    assign unused_bits = ^{rle_addr[1:0], out_addr[1:0], mem_word_addr};

endmodule

// File: tb/tb_rle_decoder.sv
// ---------------------------------------------------------------------------
// tb_rle_decoder
//
// Bench for rle_decoder with a word-wide memory that has a registered read
// port. Each frame is expanded by a queue-based model into the list of words
// and addresses that must be written; a monitor compares every memory access
// and the final out_size against that list. Literal expectations pin the
// results of the frames from the test plan.
// ---------------------------------------------------------------------------
module tb_rle_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] out_addr;
    logic [31:0] out_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:16383];
    logic        pre_we;
    logic [13:0] pre_idx;
    logic [31:0] pre_data;

    logic [7:0]  comp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_size;
    int          wr_seen;
    logic [31:0] rd_lo;
    logic [31:0] rd_hi;
    logic        mon_en;
    logic        done_q;

    rle_decoder #(.ADDR_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .out_addr        (out_addr),
        .out_size        (out_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    always #5 clk = ~clk;

    // Memory: bench preload has priority, then the DUT write; read is registered.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (port_A_we) begin
            mem[port_A_addr[15:2]] <= port_A_data_in;
        end
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return mem[a[15:2]];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Write comp_q into memory at a word-aligned address, zero padded.
    task automatic loadFrame(input logic [31:0] addr, input int size);
        logic [31:0] w;
        logic [31:0] a;
        for (int k = 0; 4 * k < size; k++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (4 * k + b < size) w[8*b +: 8] = comp_q[4*k+b];
            end
            a = addr + 32'(4 * k);
            @(negedge clk);
            pre_idx  = a[15:2];
            pre_data = w;
            pre_we   = 1'b1;
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Model: expand pairs into plaintext, then chop into little-endian words.
    task automatic buildExpected(input logic [31:0] ra, input int size,
                                 input logic [31:0] oa);
        logic [7:0]  plain[$];
        logic [31:0] w;
        plain.delete();
        for (int i = 0; i + 1 < size; i += 2) begin
            repeat (int'(comp_q[i])) plain.push_back(comp_q[i+1]);
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_size = plain.size();
        for (int k = 0; 4 * k < plain.size(); k++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (4 * k + b < plain.size()) w[8*b +: 8] = plain[4*k+b];
            end
            exp_addr_q.push_back(oa + 32'(4 * k));
            exp_data_q.push_back(w);
        end
        rd_lo   = ra;
        rd_hi   = ra + 32'(4 * ((size + 3) / 4));
        wr_seen = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] ra, input int size,
                                 input logic [31:0] oa);
        buildExpected(ra, size, oa);
        @(negedge clk);
        rle_addr = ra;
        rle_size = 32'(size);
        out_addr = oa;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int c;
        c = 0;
        while (!done && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (!done) checkOutput({name, "_timeout"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    // Compare process: every write against the model's list, every read
    // against the frame's word range, and out_size when done rises.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (port_A_we) begin
                wr_seen++;
                if (exp_addr_q.size() == 0) begin
                    checkOutput("unexpected_write_addr", {16'd0, port_A_addr}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("wr_addr", {16'd0, port_A_addr}, exp_addr_q.pop_front());
                    checkOutput("wr_data", port_A_data_in, exp_data_q.pop_front());
                end
            end else if (port_A_addr != 16'd0) begin
                checkOutput("rd_in_range",
                            32'(({16'd0, port_A_addr} >= rd_lo) && ({16'd0, port_A_addr} < rd_hi)),
                            32'd1);
            end
            if (done && !done_q) begin
                checkOutput("out_size", out_size, 32'(exp_size));
                checkOutput("writes_pending", 32'(exp_addr_q.size()), 32'd0);
            end
        end
        done_q = done;
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rle_addr = 32'd0;
        rle_size = 32'd0;
        out_addr = 32'd0;
        pre_we   = 1'b0;
        pre_idx  = 14'd0;
        pre_data = 32'd0;
        mon_en   = 1'b0;
        done_q   = 1'b0;
        exp_size = 0;
        wr_seen  = 0;
        rd_lo    = 32'd0;
        rd_hi    = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_out_size", out_size, 32'd0);
        checkOutput("rst_we", 32'(port_A_we), 32'd0);
        checkOutput("rst_addr", {16'd0, port_A_addr}, 32'd0);
        checkOutput("rst_data_in", port_A_data_in, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single run
        comp_q = '{8'h05, 8'hAA};
        loadFrame(32'hC8, 2);
        checkOutput("t1_src_word", memWord(32'hC8), 32'h0000AA05);
        applyStimulus(32'hC8, 2, 32'h200);
        waitDone("t1");
        checkOutput("t1_w0", memWord(32'h200), 32'hAAAAAAAA);
        checkOutput("t1_w1", memWord(32'h204), 32'h000000AA);
        checkOutput("t1_size", out_size, 32'd5);
        checkOutput("t1_done", 32'(done), 32'd1);

        // Round trip of a 48-byte frame held as 12 compressed bytes
        comp_q = '{8'd10, 8'h41, 8'd6, 8'h42, 8'd12, 8'h43,
                   8'd4, 8'h44, 8'd9, 8'h45, 8'd7, 8'h46};
        loadFrame(32'hC8, 12);
        applyStimulus(32'hC8, 12, 32'h300);
        waitDone("t2");
        checkOutput("t2_size", out_size, 32'd48);
        checkOutput("t2_w0", memWord(32'h300), 32'h41414141);
        checkOutput("t2_w2", memWord(32'h308), 32'h42424141);
        checkOutput("t2_writes", 32'(wr_seen), 32'd12);

        // 51-byte frame: 13 pairs of count 2 followed by 25 pairs of count 1
        comp_q.delete();
        for (int p = 0; p < 38; p++) begin
            comp_q.push_back((p < 13) ? 8'd2 : 8'd1);
            comp_q.push_back(8'h10 + 8'(p));
        end
        loadFrame(32'h12C, 76);
        applyStimulus(32'h12C, 76, 32'h400);
        waitDone("t3");
        checkOutput("t3_size", out_size, 32'd51);
        checkOutput("t3_last", memWord(32'h400 + 32'd48), 32'h00353433);
        checkOutput("t3_writes", 32'(wr_seen), 32'd13);

        // Edge counts: a zero-count pair, then a 255-byte run
        comp_q = '{8'h00, 8'h11, 8'hFF, 8'h22};
        loadFrame(32'h500, 4);
        applyStimulus(32'h500, 4, 32'h600);
        waitDone("t4");
        checkOutput("t4_size", out_size, 32'd255);
        checkOutput("t4_writes", 32'(wr_seen), 32'd64);
        checkOutput("t4_first", memWord(32'h600), 32'h22222222);
        checkOutput("t4_last", memWord(32'h600 + 32'd252), 32'h00222222);

        // Odd size: trailing count byte ignored
        comp_q = '{8'h02, 8'h33, 8'h07};
        loadFrame(32'h700, 3);
        applyStimulus(32'h700, 3, 32'h800);
        waitDone("t5");
        checkOutput("t5_word", memWord(32'h800), 32'h00003333);
        checkOutput("t5_size", out_size, 32'd2);
        checkOutput("t5_writes", 32'(wr_seen), 32'd1);

        // Zero size, restarted from DONE: no memory access at all
        comp_q.delete();
        applyStimulus(32'h900, 0, 32'hA00);
        checkOutput("t5z_done_drop", 32'(done), 32'd0);
        waitDone("t5z");
        repeat (4) @(negedge clk);
        checkOutput("t5z_size", out_size, 32'd0);
        checkOutput("t5z_writes", 32'(wr_seen), 32'd0);
        checkOutput("t5z_done", 32'(done), 32'd1);

        // Reset in the middle of the long run
        comp_q = '{8'h00, 8'h11, 8'hFF, 8'h22};
        applyStimulus(32'h500, 4, 32'hE00);
        repeat (30) @(negedge clk);
        checkOutput("t6_busy", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_done", 32'(done), 32'd0);
        checkOutput("t6_rst_size", out_size, 32'd0);
        checkOutput("t6_rst_we", 32'(port_A_we), 32'd0);
        checkOutput("t6_rst_addr", {16'd0, port_A_addr}, 32'd0);
        checkOutput("t6_rst_data", port_A_data_in, 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        rd_hi = rd_lo;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t6_idle_done", 32'(done), 32'd0);
        checkOutput("t6_idle_size", out_size, 32'd0);

        // start held while busy with other inputs must be ignored
        comp_q = '{8'd10, 8'h41, 8'd6, 8'h42, 8'd12, 8'h43,
                   8'd4, 8'h44, 8'd9, 8'h45, 8'd7, 8'h46};
        applyStimulus(32'hC8, 12, 32'hB00);
        repeat (5) @(negedge clk);
        rle_addr = 32'h12C;
        rle_size = 32'd76;
        out_addr = 32'hC00;
        start    = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        waitDone("t7");
        checkOutput("t7_size", out_size, 32'd48);
        checkOutput("t7_w2", memWord(32'hB08), 32'h42424141);
        checkOutput("t7_writes", 32'(wr_seen), 32'd12);

        // Restart from DONE: done must drop
        comp_q = '{8'h02, 8'h33, 8'h07};
        applyStimulus(32'h700, 3, 32'hD00);
        checkOutput("t8_done_drop", 32'(done), 32'd0);
        waitDone("t8");
        checkOutput("t8_word", memWord(32'hD00), 32'h00003333);
        checkOutput("t8_size", out_size, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
